// File: rtl/dpd_digit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// dpd_pkg
// Shared types and helpers for the DPD read-side datapath.
//   DECLET_W / BCD_W : field widths of a declet and a BCD digit
//   bcd_t, declet_t  : digit and declet types
//   bcd3_t           : three digits of one declet, [2] is the most significant
//   ser_state_e      : serializer FSM states
//   dpd_decode()     : full IEEE 754 densely-packed-decimal declet decoder
// -----------------------------------------------------------------------------
package dpd_pkg;

    localparam int DECLET_W = 10;
    localparam int BCD_W    = 4;

    typedef logic [BCD_W-1:0]    bcd_t;
    typedef logic [DECLET_W-1:0] declet_t;
    typedef bcd_t [2:0]          bcd3_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ser_state_e;

    // Declet bit naming: d[9:7]=pqr, d[6:4]=stu, d[3]=v, d[2:1]=wx, d[0]=y.
    // Large digits (8/9) carry only their LSB; the other bits are borrowed
    // from fields freed by the large digit. For the all-large pattern
    // (v=1, wx=11, st=11) p and q are ignored, so the 24 non-canonical
    // codes still land on valid digits.
    function automatic bcd3_t dpd_decode(input declet_t d);
        bcd3_t r;
        if (d[3] == 1'b0) begin
            r = {{1'b0, d[9:7]}, {1'b0, d[6:4]}, {1'b0, d[2:0]}};
        end else begin
            case (d[2:1])
                2'b00:   r = {{1'b0, d[9:7]},       {1'b0, d[6:4]},       {3'b100, d[0]}};
                2'b01:   r = {{1'b0, d[9:7]},       {3'b100, d[4]},       {1'b0, d[6:5], d[0]}};
                2'b10:   r = {{3'b100, d[7]},       {1'b0, d[6:4]},       {1'b0, d[9:8], d[0]}};
                default: begin
                    case (d[6:5])
                        2'b00:   r = {{3'b100, d[7]}, {3'b100, d[4]},       {1'b0, d[9:8], d[0]}};
                        2'b01:   r = {{3'b100, d[7]}, {1'b0, d[9:8], d[4]}, {3'b100, d[0]}};
                        2'b10:   r = {{1'b0, d[9:7]}, {3'b100, d[4]},       {3'b100, d[0]}};
                        default: r = {{3'b100, d[7]}, {3'b100, d[4]},       {3'b100, d[0]}};
                    endcase
                end
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/dpd_digit_serializer_if.sv
// -----------------------------------------------------------------------------
// dpd_digit_serializer_if
// Word-in / digit-out streams of the DPD digit serializer.
//   in_valid/in_ready/in_dpd : packed-declet word stream (MS declet in top bits)
//   flush                    : drop the remainder of the current word
//   out_valid/out_ready      : digit stream handshake
//   out_digit/out_last/out_idx : BCD digit, last-of-word flag, absolute position
// Modports: master = word producer / digit sink, slave = serializer.
// -----------------------------------------------------------------------------
interface dpd_digit_serializer_if #(
    parameter int NDECLETS = 2
);
    import dpd_pkg::*;

    localparam int NDIG  = 3 * NDECLETS;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic                         in_valid;
    logic                         in_ready;
    logic [DECLET_W*NDECLETS-1:0] in_dpd;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    bcd_t                         out_digit;
    logic                         out_last;
    logic [IDX_W-1:0]             out_idx;

    modport master (
        output in_valid, in_dpd, flush, out_ready,
        input  in_ready, out_valid, out_digit, out_last, out_idx
    );

    modport slave (
        input  in_valid, in_dpd, flush, out_ready,
        output in_ready, out_valid, out_digit, out_last, out_idx
    );

endinterface

// File: rtl/dpd_digit_serializer_decode.sv
// -----------------------------------------------------------------------------
// dpd_declet_decode
// Combinational single-declet DPD-to-BCD decoder, kept as its own module so it
// can be exercised standalone over every 10-bit code.
//   declet : 10-bit DPD code
//   digits : three BCD digits, digits[2] most significant
// -----------------------------------------------------------------------------
module dpd_declet_decode
    import dpd_pkg::*;
(
    input  declet_t declet,
    output bcd3_t   digits
);

    assign digits = dpd_decode(declet);

endmodule

// File: rtl/dpd_digit_serializer.sv
// -----------------------------------------------------------------------------
// dpd_digit_serializer
// Accepts a word of NDECLETS DPD declets, decodes it into 3*NDECLETS BCD digits
// and streams them out one per beat, most significant first.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : dpd_digit_serializer_if.slave (word in, digit out, flush)
// Build option: DPD_SER_ZSUP_EN enables leading-zero suppression (emission
// starts at the first non-zero digit; an all-zero word emits a single '0' at
// the last position). Without it every digit is emitted.
// -----------------------------------------------------------------------------
module dpd_digit_serializer
    import dpd_pkg::*;
#(
    parameter int NDECLETS = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    dpd_digit_serializer_if.slave bus
);

    localparam int NDIG  = 3 * NDECLETS;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    // Index 0 of every digit vector is the most significant digit.
    ser_state_e             state_r;
    ser_state_e             state_nxt_s;
    bcd_t [NDIG-1:0]        digits_r;
    bcd_t [NDIG-1:0]        digits_nxt_s;
    bcd_t [NDIG-1:0]        dec_digits_s;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [IDX_W-1:0]       start_idx_s;

    logic                   out_valid_r;
    logic                   out_last_r;
    bcd_t                   out_digit_r;
    logic                   out_valid_nxt_s;
    logic                   out_last_nxt_s;
    bcd_t                   out_digit_nxt_s;

    logic                   in_ready_s;
    logic                   accept_s;
    logic                   out_hs_s;

    genvar k;
    generate
        for (k = 0; k < NDECLETS; k++) begin : g_dec
            bcd3_t dig_s;

            // Declet k (k=0 most significant) feeds digit positions 3k..3k+2.
            dpd_declet_decode u_dec (
                .declet (bus.in_dpd[DECLET_W*(NDECLETS-k)-1 -: DECLET_W]),
                .digits (dig_s)
            );

            assign dec_digits_s[3*k]   = dig_s[2];
            assign dec_digits_s[3*k+1] = dig_s[1];
            assign dec_digits_s[3*k+2] = dig_s[0];
        end
    endgenerate

    // Start position of a freshly accepted word.
    always_comb begin
        start_idx_s = {IDX_W{1'b0}};
`ifdef DPD_SER_ZSUP_EN
        // Scan from the low end so the smallest non-zero position wins;
        // an all-zero word keeps the last position.
        start_idx_s = LAST_IDX;
        for (int i = NDIG - 2; i >= 0; i--) begin
            if (dec_digits_s[i] != 4'd0) begin
                start_idx_s = IDX_W'(i);
            end else begin
                start_idx_s = start_idx_s;
            end
        end
`endif
    end

    // A new word can be taken while idle or on the final digit handshake,
    // giving bubble-free back-to-back words; flush blocks acceptance.
    assign out_hs_s   = out_valid_r & bus.out_ready;
    assign in_ready_s = ~bus.flush & ((state_r == ST_IDLE) | (out_hs_s & out_last_r));
    assign accept_s   = bus.in_valid & in_ready_s;

    // Next-state, index and digit-register update; flush overrides everything.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        digits_nxt_s = digits_r;
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
        end else if (accept_s) begin
            state_nxt_s  = ST_EMIT;
            idx_nxt_s    = start_idx_s;
            digits_nxt_s = dec_digits_s;
        end else if (out_hs_s && !out_last_r) begin
            idx_nxt_s = idx_r + IDX_W'(1);
        end else if (out_hs_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output values for the next cycle; registered below so outputs come from flops.
    always_comb begin
        out_valid_nxt_s = (state_nxt_s == ST_EMIT);
        out_digit_nxt_s = digits_nxt_s[idx_nxt_s];
        if (out_valid_nxt_s) begin
            out_last_nxt_s = (idx_nxt_s == LAST_IDX);
        end else begin
            out_last_nxt_s = 1'b0;
        end
    end

    // State, digit register, index and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            digits_r    <= {(NDIG*BCD_W){1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_digit_r <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            digits_r    <= digits_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_last_r  <= out_last_nxt_s;
            out_digit_r <= out_digit_nxt_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_digit = out_digit_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_idx   = idx_r;

endmodule

// File: tb/tb_dpd_digit_serializer.sv
// -----------------------------------------------------------------------------
// tb_dpd_digit_serializer
// Self-checking bench for dpd_digit_serializer (NDECLETS=2). Expected digits
// come from a reference table built from a BCD->DPD encoder; expected beats
// are queued on each accepted word and compared as digits are handed off.
// Honours DPD_SER_ZSUP_EN in its model.
// -----------------------------------------------------------------------------
module tb_dpd_digit_serializer;
    import dpd_pkg::*;

    localparam int NDECLETS = 2;
    localparam int NDIG     = 6;

    logic clk = 1'b0;
    logic rst_n;

    dpd_digit_serializer_if #(.NDECLETS(NDECLETS)) dif ();

    dpd_digit_serializer #(.NDECLETS(NDECLETS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    declet_t sweep_code;
    bcd3_t   sweep_digits;

    dpd_declet_decode u_ref_dec (
        .declet (sweep_code),
        .digits (sweep_digits)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [2:0] idx;
        logic [3:0] digit;
    } beat_t;

    beat_t       exp_q[$];
    logic [11:0] dec_ref [1024];
    int          n_cmp = 0;
    int          n_err = 0;
    int          beats = 0;
    int          gap_cnt = 0;
    logic        track_gap = 1'b0;
    logic        acc_on_last = 1'b0;
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_out = 9'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference BCD->DPD encoder (a = most significant digit).
    function automatic logic [9:0] dpd_encode(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        logic [9:0] e;
        case ({a[3], b[3], c[3]})
            3'b000:  e = {a[2:0], b[2:0], 1'b0, c[2:0]};
            3'b001:  e = {a[2:0], b[2:0], 1'b1, 2'b00, c[0]};
            3'b010:  e = {a[2:0], c[2:1], b[0], 1'b1, 2'b01, c[0]};
            3'b100:  e = {c[2:1], a[0], b[2:0], 1'b1, 2'b10, c[0]};
            3'b110:  e = {c[2:1], a[0], 2'b00, b[0], 1'b1, 2'b11, c[0]};
            3'b101:  e = {b[2:1], a[0], 2'b01, b[0], 1'b1, 2'b11, c[0]};
            3'b011:  e = {a[2:0], 2'b10, b[0], 1'b1, 2'b11, c[0]};
            default: e = {2'b00, a[0], 2'b11, b[0], 1'b1, 2'b11, c[0]};
        endcase
        return e;
    endfunction

    task automatic push_word(input logic [19:0] w);
        logic [3:0]  d [6];
        logic [11:0] t;
        int          start;
        logic        found;
        beat_t       b;
        for (int k = 0; k < 2; k++) begin
            t = dec_ref[w[19-10*k -: 10]];
            d[3*k]   = t[11:8];
            d[3*k+1] = t[7:4];
            d[3*k+2] = t[3:0];
        end
        start = 0;
        found = 1'b0;
`ifdef DPD_SER_ZSUP_EN
        start = NDIG - 1;
        for (int i = 0; i < NDIG - 1; i++) begin
            if (!found && d[i] != 4'd0) begin
                start = i;
                found = 1'b1;
            end
        end
`endif
        for (int i = start; i < NDIG; i++) begin
            b.last  = (i == NDIG - 1);
            b.idx   = 3'(i);
            b.digit = d[i];
            exp_q.push_back(b);
        end
    endtask

    // Scoreboard monitor: pops on digit handshakes, pushes on word accepts,
    // and checks that stalled outputs hold.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else if (dif.flush) begin
            exp_q.delete();
        end else begin
            if (dif.out_valid && dif.out_ready) begin
                beats++;
                check_val("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("digit", dif.out_digit, e.digit);
                    check_val("idx", dif.out_idx, e.idx);
                    check_val("last", dif.out_last, e.last);
                end
            end
            if (dif.in_valid && dif.in_ready) begin
                acc_on_last = dif.out_last;
                push_word(dif.in_dpd);
            end
        end
        if (track_gap && !dif.out_valid) gap_cnt++;
        if (prev_stall) begin
            check_val("stall_hold", {dif.out_valid, dif.out_last, dif.out_idx, dif.out_digit}, prev_out);
        end
        prev_stall = rst_n && !dif.flush && dif.out_valid && !dif.out_ready;
        prev_out   = {dif.out_valid, dif.out_last, dif.out_idx, dif.out_digit};
    end

    // Offer a word from posedge+1 until accepted; returns at posedge+1 after the accept edge.
    task automatic send_word(input logic [19:0] w);
        int n = 0;
        dif.in_valid = 1'b1;
        dif.in_dpd   = w;
        @(negedge clk);
        while (!dif.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_in_time", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((exp_q.size() != 0 || dif.out_valid) && n < 400) begin
            if (rnd) dif.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_in_time", 32'(n < 400), 32'd1);
        dif.out_ready = 1'b1;
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (!(dif.out_valid && dif.out_idx == 3'(target)) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("reach_idx", 32'(n < 50), 32'd1);
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_dpd    = 20'd0;
        dif.flush     = 1'b0;
        dif.out_ready = 1'b0;
        sweep_code    = 10'd0;

        // Reference table: canonical codes from the encoder; the 24
        // non-canonical codes decode as their p=q=0 counterpart.
        for (int c = 0; c < 1024; c++) dec_ref[c] = 12'hFFF;
        for (int a = 0; a < 10; a++)
            for (int b = 0; b < 10; b++)
                for (int c = 0; c < 10; c++)
                    dec_ref[dpd_encode(4'(a), 4'(b), 4'(c))] = {4'(a), 4'(b), 4'(c)};
        for (int c = 0; c < 1024; c++)
            if (dec_ref[c] == 12'hFFF) dec_ref[c] = dec_ref[c & 32'h0FF];

        // Standalone decoder sweep
        sweep_code = 10'h0A3; #1;
        check_val("dec_0a3", sweep_digits, 12'h123);
        sweep_code = 10'h0FF; #1;
        check_val("dec_0ff", sweep_digits, 12'h999);
        for (int c = 0; c < 1024; c++) begin
            sweep_code = 10'(c);
            #1;
            check_val("sweep", sweep_digits, dec_ref[c]);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", dif.out_valid, 32'd0);
        check_val("rst_last", dif.out_last, 32'd0);
        check_val("rst_digit", dif.out_digit, 32'd0);
        check_val("rst_idx", dif.out_idx, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("idle_in_ready", dif.in_ready, 32'd1);

        // 1. Single word, latency
        dif.out_ready = 1'b1;
        send_word({10'h0A3, 10'h0FF});
        check_val("lat_valid", dif.out_valid, 32'd1);
        check_val("lat_idx", dif.out_idx, 32'd0);
        drain(1'b0);

        // 2. Back-to-back words, no bubble
        beats   = 0;
        gap_cnt = 0;
        send_word({10'h0FF, 10'h0A3});
        track_gap = 1'b1;
        send_word({10'h3FF, 10'h2A5});
        check_val("accept_on_last", acc_on_last, 32'd1);
        n = 0;
        while (beats < 12 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        track_gap = 1'b0;
        check_val("b2b_beats", beats, 32'd12);
        check_val("b2b_gaps", gap_cnt, 32'd0);
        drain(1'b0);

        // 3. Random backpressure
        send_word({10'h2A5, 10'h3FF}); drain(1'b1);
        send_word({10'h15B, 10'h06E}); drain(1'b1);
        send_word({10'h3EF, 10'h0A3}); drain(1'b1);
        send_word({10'h1D7, 10'h37E}); drain(1'b1);

        // 4. Flush at idx 2
        send_word({10'h0FF, 10'h0FF});
        wait_idx(2);
        dif.flush     = 1'b1;
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.in_dpd    = {10'h2A5, 10'h0A3};
        @(negedge clk);
        check_val("flush_in_ready", dif.in_ready, 32'd0);
        @(posedge clk);
        #1;
        check_val("flush_valid", dif.out_valid, 32'd0);
        dif.flush     = 1'b0;
        dif.out_ready = 1'b1;
        @(negedge clk);
        check_val("post_flush_ready", dif.in_ready, 32'd1);
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        check_val("post_flush_valid", dif.out_valid, 32'd1);
        check_val("post_flush_idx", dif.out_idx, 32'd0);
        drain(1'b0);

        // 5. Reset at idx 4
        send_word({10'h2A5, 10'h3FF});
        wait_idx(4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_valid", dif.out_valid, 32'd0);
        check_val("midrst_last", dif.out_last, 32'd0);
        check_val("midrst_digit", dif.out_digit, 32'd0);
        check_val("midrst_idx", dif.out_idx, 32'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_val("no_partial", dif.out_valid, 32'd0);
        end
        send_word({10'h0A3, 10'h0FF});
        check_val("rst_lat_valid", dif.out_valid, 32'd1);
        drain(1'b0);

        // 6. Leading zeros
        send_word({10'h000, 10'h0A3});
`ifdef DPD_SER_ZSUP_EN
        check_val("zs_first_idx", dif.out_idx, 32'd3);
        check_val("zs_first_digit", dif.out_digit, 32'd1);
`else
        check_val("nz_first_idx", dif.out_idx, 32'd0);
        check_val("nz_first_digit", dif.out_digit, 32'd0);
`endif
        drain(1'b0);
        send_word({10'h000, 10'h000});
`ifdef DPD_SER_ZSUP_EN
        check_val("zero_last", dif.out_last, 32'd1);
        check_val("zero_idx", dif.out_idx, 32'd5);
`else
        check_val("zero_last", dif.out_last, 32'd0);
        check_val("zero_idx", dif.out_idx, 32'd0);
`endif
        drain(1'b0);
        send_word({10'h000, 10'h001});
        drain(1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
